// File: rtl/cpu_if_pkg.sv
// Shared types for the multi-requester CPU interface controller.
// Optional err_count output: define CPU_IF_ERR_COUNT_EN.
package cpu_if_pkg;

  localparam int NUM_REQ_DEF = 2;
  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 16;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } cpu_if_state_e;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } cpu_if_acc_t;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_if_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after rr_ptr.
// Part of cpu_if_access_ctrl (optional CPU_IF_ERR_COUNT_EN lives in the top).
module cpu_if_rr_arbiter
  import cpu_if_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  localparam int IDX_W  = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  logic found;
  int   j;

  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

  assign any_req = |req;
  assign grant   = found ? (NUM_REQ'(1) << grant_idx) : '0;

endmodule

// File: rtl/cpu_if_access_ctrl.sv
// Round-robin CPU interface controller driving one bus access at a time.
// Define CPU_IF_ERR_COUNT_EN to add the saturating err_count output.
module cpu_if_access_ctrl
  import cpu_if_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_error,
  output logic                      access_ready,
  output logic                      bus_valid,
  output logic                      bus_write,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [DATA_W-1:0]         bus_wdata,
  input  logic [DATA_W-1:0]         bus_rdata,
`ifdef CPU_IF_ERR_COUNT_EN
  output logic [15:0]               err_count,
`endif
  input  logic                      bus_complete
);

  localparam int IDX_W = idx_w(NUM_REQ);

  cpu_if_state_e     state_q, state_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [IDX_W-1:0]  gnt_q, gnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               any_req;

  cpu_if_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (any_req)
  );

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = arb_idx;
          write_d = req_write[arb_idx];
          addr_d  = req_addr[arb_idx*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[arb_idx*DATA_W +: DATA_W];
          rr_d    = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
          cnt_d   = '0;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        // Completion outranks a timeout landing on the same cycle.
        if (bus_complete) begin
          rdata_d = write_q ? '0 : bus_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (TIMEOUT_CYC != 0 &&
                     cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign access_ready = (state_q == IDLE);
  assign bus_valid    = (state_q == ACTIVE);
  assign req_ready    = (state_q == IDLE) ? arb_grant : '0;
  assign rsp_valid    = (state_q == RESP) ? (NUM_REQ'(1) << gnt_q) : '0;
  assign rsp_rdata    = rdata_q;
  assign rsp_error    = err_q;
  assign bus_write    = write_q;
  assign bus_addr     = addr_q;
  assign bus_wdata    = wdata_q;

`ifdef CPU_IF_ERR_COUNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (state_q == RESP && err_q && err_cnt_q != 16'hFFFF)
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule
